// File: rtl/ws2812_tx_if.sv
// Pixel stream into the WS2812 serializer: 24-bit GRB pixel, frame marker, valid/ready.
interface ws2812_tx_if;
   logic [23:0] pix_data;
   logic        pix_valid;
   logic        pix_last;
   logic        pix_ready;

   modport master (output pix_data, output pix_valid, output pix_last, input pix_ready);
   modport slave  (input pix_data, input pix_valid, input pix_last, output pix_ready);
endinterface

// File: rtl/ws2812_tx.sv
// Streaming WS2812 serializer: GRB pixels in over valid/ready, MSB-first slot-coded bits out,
// each frame closed by a latch gap. A one-pixel holding register keeps frames gapless.
module ws2812_tx #(
   parameter int SLOT_CYCLES = 4,
   parameter int RESET_SLOTS = 200,
   parameter bit INVERT      = 1'b1
) (
   input  logic       CLK,
   input  logic       RST,
   ws2812_tx_if.slave pix,
   output logic       ws_out,
   output logic       busy,
   output logic       underrun
);

   localparam int SC_W         = (SLOT_CYCLES > 1) ? $clog2(SLOT_CYCLES) : 1;
   localparam int LATCH_CYCLES = RESET_SLOTS * SLOT_CYCLES;
   localparam int LC_W         = (LATCH_CYCLES > 1) ? $clog2(LATCH_CYCLES) : 1;

   localparam logic [SC_W-1:0] SLOT_LAST  = SC_W'(SLOT_CYCLES - 1);
   localparam logic [LC_W-1:0] LATCH_LAST = LC_W'(LATCH_CYCLES - 1);

   localparam logic [1:0] S_IDLE  = 2'd0;
   localparam logic [1:0] S_LOAD  = 2'd1;
   localparam logic [1:0] S_BIT   = 2'd2;
   localparam logic [1:0] S_LATCH = 2'd3;

   logic [1:0]      state, state_nxt;
   logic [23:0]     hold_data;
   logic            hold_last;
   logic            hold_full, hold_full_nxt;
   logic [23:0]     shift, shift_nxt;
   logic            last_r, last_nxt;
   logic [4:0]      bitcnt, bitcnt_nxt;
   logic [1:0]      slot, slot_nxt;
   logic [SC_W-1:0] slotcnt, slotcnt_nxt;
   logic [LC_W-1:0] latchcnt, latchcnt_nxt;
   logic            busy_nxt, underrun_nxt, line_nxt;

   logic accept, slot_end, bit_end, pix_end, latch_end, load;

   assign pix.pix_ready = ~hold_full;
   assign accept        = pix.pix_valid & ~hold_full;

   assign slot_end  = (slotcnt == SLOT_LAST);
   assign bit_end   = slot_end && (slot == 2'd3);
   assign pix_end   = bit_end && (bitcnt == 5'd23);
   assign latch_end = (latchcnt == LATCH_LAST);

   // A reload at the end of bit 23 does the LOAD work in place, so pixels abut with no gap.
   assign load = (state == S_LOAD) ||
                 ((state == S_BIT) && pix_end && !last_r && hold_full);

   always_comb begin
      state_nxt    = state;
      shift_nxt    = shift;
      last_nxt     = last_r;
      bitcnt_nxt   = bitcnt;
      slot_nxt     = slot;
      slotcnt_nxt  = slotcnt;
      latchcnt_nxt = latchcnt;
      underrun_nxt = 1'b0;

      case (state)
         S_IDLE: begin
            if (hold_full) state_nxt = S_LOAD;
         end
         S_LOAD: begin
            state_nxt = S_BIT;
         end
         S_BIT: begin
            slotcnt_nxt = slot_end ? '0 : slotcnt + SC_W'(1);
            if (slot_end) slot_nxt = slot + 2'd1;
            if (bit_end) begin
               shift_nxt  = {shift[22:0], 1'b0};
               bitcnt_nxt = bitcnt + 5'd1;
            end
            if (pix_end) begin
               bitcnt_nxt = '0;
               if (last_r || !hold_full) begin
                  state_nxt    = S_LATCH;
                  underrun_nxt = ~last_r;
               end
            end
         end
         S_LATCH: begin
            latchcnt_nxt = latch_end ? '0 : latchcnt + LC_W'(1);
            if (latch_end) state_nxt = S_IDLE;
         end
         default: state_nxt = S_IDLE;
      endcase

      if (load) begin
         state_nxt   = S_BIT;
         shift_nxt   = hold_data;
         last_nxt    = hold_last;
         bitcnt_nxt  = '0;
         slot_nxt    = '0;
         slotcnt_nxt = '0;
      end

      // Line level is derived from the state being entered so ws_out can stay registered.
      line_nxt = (state_nxt == S_BIT) &&
                 ((slot_nxt == 2'd0) || ((slot_nxt == 2'd1) && shift_nxt[23]));

      if (accept)          hold_full_nxt = 1'b1;
      else if (load)       hold_full_nxt = 1'b0;
      else                 hold_full_nxt = hold_full;

      // A pixel parked during the latch gap keeps busy asserted across the return to IDLE.
      if (accept)                              busy_nxt = 1'b1;
      else if ((state == S_LATCH) && latch_end) busy_nxt = hold_full;
      else                                     busy_nxt = busy;
   end

   always_ff @(posedge CLK) begin
      if (RST) begin
         state     <= S_IDLE;
         hold_full <= 1'b0;
         bitcnt    <= '0;
         slot      <= '0;
         slotcnt   <= '0;
         latchcnt  <= '0;
         ws_out    <= INVERT;
         busy      <= 1'b0;
         underrun  <= 1'b0;
      end else begin
         state     <= state_nxt;
         hold_full <= hold_full_nxt;
         bitcnt    <= bitcnt_nxt;
         slot      <= slot_nxt;
         slotcnt   <= slotcnt_nxt;
         latchcnt  <= latchcnt_nxt;
         ws_out    <= INVERT ^ line_nxt;
         busy      <= busy_nxt;
         underrun  <= underrun_nxt;
      end
   end

   always_ff @(posedge CLK) begin
      if (accept) begin
         hold_data <= pix.pix_data;
         hold_last <= pix.pix_last;
      end
      shift  <= shift_nxt;
      last_r <= last_nxt;
   end

endmodule

// File: tb/tb_ws2812_tx.sv
// Directed bench for ws2812_tx: a line decoder pops expected bits from a scoreboard queue
// filled at each pixel accept; frame timing is checked against cycle counts.
module tb_ws2812_tx;
   localparam int SC   = 4;
   localparam int RS   = 200;
   localparam bit INV  = 1'b1;
   localparam int BITP = 4 * SC;
   localparam int PIXP = 24 * BITP;
   localparam int LATP = RS * SC;

   typedef struct packed {
      logic b;
      logic first;
   } exp_t;

   logic CLK = 1'b0;
   logic RST;
   logic ws_out, busy, underrun;

   int   cyc = 0;
   int   total = 0;
   int   bad = 0;
   exp_t sb[$];
   int   rises = 0;
   int   frame_rises = 0;
   int   frame_rise = 0;
   int   last_rise = 0;

   ws2812_tx_if ifc ();

   ws2812_tx #(
      .SLOT_CYCLES(SC),
      .RESET_SLOTS(RS),
      .INVERT     (INV)
   ) dut (
      .CLK     (CLK),
      .RST     (RST),
      .pix     (ifc),
      .ws_out  (ws_out),
      .busy    (busy),
      .underrun(underrun)
   );

   always #5 CLK = ~CLK;
   always @(posedge CLK) cyc <= cyc + 1;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
      end
   endtask

   // Line decoder: pulse width gives the bit, rise spacing inside a frame must be one bit period.
   initial begin
      int         hi_len;
      logic       prev_line;
      logic       line;
      exp_t       e;
      logic [1:0] dec;
      hi_len    = 0;
      prev_line = 1'b0;
      forever begin
         @(negedge CLK);
         line = ws_out ^ INV;
         if (RST === 1'b1) begin
            hi_len    = 0;
            prev_line = 1'b0;
         end else begin
            if (line === 1'b1 && prev_line === 1'b0) begin
               rises++;
               chk("pulse_expected", 32'(sb.size() != 0), 32'd1);
               if (sb.size() != 0) begin
                  if (!sb[0].first) chk("bit_spacing", cyc - last_rise, BITP);
                  else begin
                     frame_rise = cyc;
                     frame_rises++;
                  end
               end
               last_rise = cyc;
            end
            if (line === 1'b1) hi_len++;
            else if (prev_line === 1'b1) begin
               dec = (hi_len == 2 * SC) ? 2'b01 : ((hi_len == SC) ? 2'b00 : 2'b10);
               if (sb.size() != 0) begin
                  e = sb.pop_front();
                  chk("bit_value", 32'(dec), 32'({1'b0, e.b}));
               end
               hi_len = 0;
            end
            prev_line = (line === 1'b1);
         end
      end
   end

   task automatic send(input logic [23:0] d, input logic l, input logic first, output int acc);
      int   n;
      exp_t e;
      n = 0;
      @(negedge CLK);
      ifc.pix_data  = d;
      ifc.pix_last  = l;
      ifc.pix_valid = 1'b1;
      while (ifc.pix_ready !== 1'b1 && n < 2000) begin
         @(negedge CLK);
         n++;
      end
      chk("accept_bound", 32'(n < 2000), 32'd1);
      @(negedge CLK);
      acc = cyc;
      for (int i = 23; i >= 0; i--) begin
         e.b     = d[i];
         e.first = first && (i == 23);
         sb.push_back(e);
      end
   endtask

   task automatic wait_busy_low(output int ev);
      int n;
      n = 0;
      while (busy !== 1'b0 && n < 4000) begin
         @(negedge CLK);
         n++;
      end
      chk("busy_fall_bound", 32'(n < 4000), 32'd1);
      ev = cyc;
   endtask

   task automatic wait_frame(input int r0, output int ev);
      int n;
      n = 0;
      while (frame_rises == r0 && n < 3000) begin
         @(negedge CLK);
         n++;
      end
      chk("frame_start_bound", 32'(n < 3000), 32'd1);
      ev = frame_rise;
   endtask

   initial begin
      #1_000_000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1);
   end

   initial begin
      int k, a1, a2, a3, ev, u, r, n;
      RST           = 1'b1;
      ifc.pix_valid = 1'b0;
      ifc.pix_data  = '0;
      ifc.pix_last  = 1'b0;
      repeat (3) @(negedge CLK);
      RST = 1'b0;

      // Reset state held through 100 idle clocks: {ws_out, ready, busy, underrun}
      for (int i = 0; i < 100; i++) begin
         @(negedge CLK);
         chk("idle_outputs", 32'({ws_out, ifc.pix_ready, busy, underrun}), 32'(4'b1100));
      end

      // Single-pixel frame
      r = frame_rises;
      send(24'hFF0000, 1'b1, 1'b1, k);
      ifc.pix_valid = 1'b0;
      wait_frame(r, ev);
      chk("t1_first_active", ev - k, 2);
      wait_busy_low(ev);
      chk("t1_busy_span", ev - k, 2 + PIXP + LATP);
      chk("t1_sb_drained", sb.size(), 0);
      repeat (5) @(negedge CLK);

      // Three-pixel gapless frame with valid held high
      send(24'h000001, 1'b0, 1'b1, a1);
      send(24'h800000, 1'b0, 1'b0, a2);
      chk("t3_ready_low_after_2nd", 32'(ifc.pix_ready), 32'd0);
      send(24'hAAAAAA, 1'b1, 1'b0, a3);
      ifc.pix_valid = 1'b0;
      chk("t3_accept2_at_load", a2 - a1, 3);
      chk("t3_accept3_at_reload", a3 - a1, 3 + PIXP);
      wait_busy_low(ev);
      chk("t3_first_active", frame_rise - a1, 2);
      chk("t3_busy_span", ev - a1, 2 + 3 * PIXP + LATP);
      chk("t3_sb_drained", sb.size(), 0);
      repeat (5) @(negedge CLK);

      // Underrun: non-last pixel with no follower
      send(24'h123456, 1'b0, 1'b1, k);
      ifc.pix_valid = 1'b0;
      n = 0;
      while (underrun !== 1'b1 && n < 1000) begin
         @(negedge CLK);
         n++;
      end
      chk("t4_underrun_bound", 32'(n < 1000), 32'd1);
      u = cyc;
      chk("t4_underrun_time", u - k, 2 + PIXP);
      @(negedge CLK);
      chk("t4_underrun_one_cycle", 32'(underrun), 32'd0);
      wait_busy_low(ev);
      chk("t4_busy_span", ev - k, 2 + PIXP + LATP);
      chk("t4_sb_drained", sb.size(), 0);
      repeat (5) @(negedge CLK);

      // Back-to-back frames: second pixel accepted during the latch gap
      r = frame_rises;
      send(24'h00FF00, 1'b1, 1'b1, k);
      ifc.pix_valid = 1'b0;
      wait_frame(r, ev);
      chk("t5_first_active", ev - k, 2);
      r = frame_rises;
      while (cyc < k + 400) @(negedge CLK);
      send(24'hF0F00F, 1'b1, 1'b1, a1);
      ifc.pix_valid = 1'b0;
      chk("t5_accept_in_latch", a1 - k, 402);
      wait_frame(r, ev);
      chk("t5_second_active", ev - k, 2 + PIXP + LATP + 2);
      wait_busy_low(ev);
      chk("t5_busy_end", ev - k, 2 + PIXP + LATP + 2 + PIXP + LATP);
      chk("t5_sb_drained", sb.size(), 0);
      repeat (5) @(negedge CLK);

      // Reset in bit 10 with a pixel waiting in the holding register
      send(24'hC3C3C3, 1'b0, 1'b1, k);
      send(24'h5A5A5A, 1'b1, 1'b0, a2);
      ifc.pix_valid = 1'b0;
      chk("t6_hold_full", 32'(ifc.pix_ready), 32'd0);
      while (cyc < k + 2 + 10 * BITP + 9) @(negedge CLK);
      RST = 1'b1;
      @(negedge CLK);
      chk("t6_after_reset", 32'({ws_out, ifc.pix_ready, busy, underrun}), 32'(4'b1100));
      RST = 1'b0;
      sb.delete();
      r = rises;
      for (int i = 0; i < 1500; i++) begin
         @(negedge CLK);
         chk("t6_line_idle", 32'({ws_out, busy}), 32'(2'b10));
      end
      chk("t6_no_pulses", rises - r, 0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
